res_pulse_formatter: RTL and testbench
======================================

Name: res_pulse_formatter

Overview:
- Sits directly upstream of the response monitors, between the DUT result port and the monitor res_valid/res_data inputs.
- The monitors capture only on a rising edge of res_valid. This block buffers DUT result beats, which may arrive back-to-back, in a FIFO.
- It replays each beat as a distinct res_valid pulse, held HOLD_CYCLES high then GAP_CYCLES low, so every result produces exactly one capturable edge.
- Overflow is counted, never silent.

Parameters:
- DATA_WIDTH, 256, width of in_data/res_data (1..256)
- FIFO_DEPTH, 8, entries; power of 2, >= 2
- HOLD_CYCLES, 1, cycles res_valid stays high per result (>= 1)
- GAP_CYCLES, 1, minimum cycles res_valid stays low between results (>= 1)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  DUT result beat valid
- in_data  input  DATA_WIDTH  DUT result beat
- in_ready  output  1  FIFO not full (combinational from registered level)
- res_valid  output  1  pulsed result valid, to monitor
- res_data  output  DATA_WIDTH  result, stable while res_valid high
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- drop_cnt  output  16  beats dropped on full FIFO, saturating
- busy  output  1  state != IDLE or level != 0

Behaviour:
- Reset (async, immediate):
  - res_valid=0, res_data=0, level=0, drop_cnt=0, busy=0, state=IDLE.
  - FIFO pointers cleared and contents discarded.
  - Reset mid-pulse drops res_valid at once, with no completion.
- Push:
  - Occurs on in_valid && in_ready at the clock edge.
  - in_ready = (level != FIFO_DEPTH). A pop in the same cycle does NOT enable a push when full.
- Drop: in_valid && !in_ready increments drop_cnt, saturating at 0xFFFF.
- Simultaneous push and pop (not full): level unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH; level covers 0..FIFO_DEPTH inclusive.
- State machine, with down-counter cnt:
  - IDLE: if level != 0, pop head into res_data, set res_valid=1, cnt=HOLD_CYCLES-1, go to HOLD. Otherwise remain.
  - HOLD: if cnt==0, set res_valid=0, cnt=GAP_CYCLES-1, go to GAP. Otherwise cnt--.
  - GAP: if cnt==0 and level != 0, pop the next entry, set res_valid=1, cnt=HOLD_CYCLES-1, go to HOLD. If cnt==0 and level==0, go to IDLE. Otherwise cnt--.
- Latency:
  - A beat pushed at edge E into an empty FIFO with state IDLE gives res_valid high after edge E+1.
  - Steady-state throughput is one result per HOLD_CYCLES+GAP_CYCLES cycles.
- res_data holds its last value during GAP/IDLE and changes only when a pop loads it.
- Order is strictly FIFO. No beat is duplicated, and none is lost unless counted in drop_cnt.
- The pop decision uses the registered level, so a beat pushed at edge E is not popped at edge E.

Test Plan:
- Reset values: assert rst_n=0 mid-run with res_valid high -> res_valid, level, drop_cnt, busy all 0 immediately; after release, no stale data is emitted.
- Single beat: DEPTH=8, HOLD=1, GAP=1, one push 0xA5 at edge 0 -> res_valid high for exactly cycle 1 with res_data=0xA5, busy=0 by cycle 3, monitor logs 1 entry.
- Back-to-back burst: DEPTH=4, HOLD=1, GAP=1, push 0x11,0x22,0x33,0x44 on consecutive edges -> res_valid pattern 1,0,1,0,1,0,1 with data 11,22,33,44 (4 rising edges), drop_cnt=0.
- Overflow: DEPTH=4, HOLD=3, GAP=2, push A..F on edges 0..5 -> F dropped (level=4 at edge 5), drop_cnt=1, outputs A,B,C,D,E in order, each high 3 cycles with a gap of 2.
- Simultaneous push/pop at wrap: DEPTH=4, continuous push at one beat per HOLD+GAP for 20 beats -> level stays constant, pointers wrap 5 times, all 20 values emitted in order.
- drop_cnt saturation: hold in_valid with FIFO full for 70000 cycles -> drop_cnt=0xFFFF and stays there.

Source files
------------

// File: rtl/res_pulse_formatter.sv
`default_nettype none
// ============================================================================
// Module   : res_pulse_formatter
// Brief    : Buffers DUT result beats in a FIFO and replays each one as a
//            separate res_valid pulse (HOLD_CYCLES high, GAP_CYCLES low), so
//            an edge-triggered monitor sees exactly one rising edge per beat.
//            Beats arriving while the FIFO is full are counted in drop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module res_pulse_formatter #(
   parameter int DATA_WIDTH  = 256,
   parameter int FIFO_DEPTH  = 8,
   parameter int HOLD_CYCLES = 1,
   parameter int GAP_CYCLES  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   output logic                          res_valid,
   output logic [DATA_WIDTH-1:0]         res_data,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic [15:0]                   drop_cnt,
   output logic                          busy
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LW     = AW + 1;
   localparam int MAXCYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW     = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_valid_nxt;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_not_empty;
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

   // Accept/drop decisions use only the registered level: a pop in the same
   // cycle never frees space for a push.
   assign in_ready    = (level != FULL_LVL);
   assign w_push      = in_valid && in_ready;
   assign w_drop      = in_valid && !in_ready;
   assign w_not_empty = (level != '0);
   assign busy        = (r_state != S_IDLE) || w_not_empty;

   // FIFO storage: contents need no reset, only the pointers do.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // FIFO pointers, occupancy and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         level    <= '0;
         drop_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (w_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Pulse state register; res_data only changes when a pop loads it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         res_valid <= w_valid_nxt;
         if (w_pop) begin
            res_data <= r_mem[r_rd_ptr];
         end
      end
   end

   // Next-state logic: IDLE pops as soon as data is present, HOLD keeps the
   // pulse high, GAP enforces the low time before the next pop.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = res_valid;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_not_empty) begin
               w_pop       = 1'b1;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = HOLD_LOAD;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = GAP_LOAD;
               w_state_nxt = S_GAP;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_GAP: begin
            if (r_cnt == '0) begin
               if (w_not_empty) begin
                  w_pop       = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_cnt_nxt   = HOLD_LOAD;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_res_pulse_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_res_pulse_formatter
// Brief    : Self-checking bench for res_pulse_formatter. A reference model
//            tracks queue contents and pulse timing arithmetically; a monitor
//            checks each emitted pulse against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_pulse_formatter;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int H     = 5;
   localparam int G     = 3;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic [LW-1:0] level;
   logic [15:0]   drop_cnt;
   logic          busy;

   int checks = 0;
   int fails  = 0;

   // Reference model state
   logic [DW-1:0] mq[$];      // beats held in the model FIFO
   logic [DW-1:0] exp_q[$];   // scoreboard: beats expected on res_data, in order
   int            cyc;
   int            next_allowed;
   int            last_pop;
   int            drops;

   res_pulse_formatter #(
      .DATA_WIDTH  (DW),
      .FIFO_DEPTH  (DEPTH),
      .HOLD_CYCLES (H),
      .GAP_CYCLES  (G)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .level     (level),
      .drop_cnt  (drop_cnt),
      .busy      (busy)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Single comparison point
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      mq.delete();
      exp_q.delete();
      drops        = 0;
      next_allowed = 0;
      last_pop     = -1000;
   endfunction

   // One clock: drive inputs, advance the model across the edge, then compare.
   // Pops occur at the first edge at or after the previous pop + H + G where
   // the pre-edge occupancy is nonzero.
   task automatic step(input logic v, input logic [DW-1:0] d);
      int  l;
      bit  pop;
      bit  acc;
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      l   = mq.size();
      pop = (l > 0) && (cyc >= next_allowed);
      acc = v && (l != DEPTH);
      if (v && !acc && drops < 65535) drops++;
      if (pop) begin
         exp_q.push_back(mq.pop_front());
         next_allowed = cyc + H + G;
         last_pop     = cyc;
      end
      if (acc) mq.push_back(d);
      #1;
      chk("level",     64'(level),     64'(mq.size()));
      chk("drop_cnt",  64'(drop_cnt),  64'(drops));
      chk("res_valid", 64'(res_valid), 64'(cyc < last_pop + H));
      chk("busy",      64'(busy),      64'((mq.size() != 0) || (cyc < next_allowed)));
      chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && !(mq.size() == 0 && cyc >= next_allowed); k++) step(1'b0, '0);
      @(negedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every rising edge of res_valid must carry the next expected beat,
   // and res_data must stay stable while res_valid is high.
   initial begin
      logic          prev;
      logic [DW-1:0] held;
      prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (res_valid && !prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_pulse: got data %0h expected no pulse (t=%0t)", res_data, $time);
            end else begin
               chk("pulse_data", 64'(res_data), 64'(exp_q.pop_front()));
            end
            held = res_data;
         end else if (res_valid) begin
            chk("data_stable", 64'(res_data), 64'(held));
         end
         prev = res_valid;
      end
   end

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      cyc      = 0;
      model_clear();

      // Reset values
      #1;
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_data",  64'(res_data),  64'd0);
      chk("rst_level",     64'(level),     64'd0);
      chk("rst_drop_cnt",  64'(drop_cnt),  64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single beat
      step(1'b1, 16'h00A5);
      idle(12);
      drain();

      // Back-to-back burst of DEPTH beats
      step(1'b1, 16'h0011);
      step(1'b1, 16'h0022);
      step(1'b1, 16'h0033);
      step(1'b1, 16'h0044);
      drain();

      // Overflow: six consecutive beats, the last one is dropped
      for (int i = 0; i < 6; i++) step(1'b1, 16'h00A0 + 16'(i));
      chk("overflow_drop", 64'(drop_cnt), 64'd1);
      drain();

      // Steady stream at the pulse rate, wrapping the pointers several times
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 16'h0100 + 16'(i));
         idle(H + G - 1);
      end
      drain();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), 16'($urandom));
      end
      drain();

      // Asynchronous reset in the middle of a pulse
      step(1'b1, 16'hBEEF);
      step(1'b1, 16'hCAFE);
      step(1'b1, 16'hF00D);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", 64'(res_valid), 64'd0);
      chk("midrst_level",     64'(level),     64'd0);
      chk("midrst_drop_cnt",  64'(drop_cnt),  64'd0);
      chk("midrst_busy",      64'(busy),      64'd0);
      model_clear();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      drain();

      // drop_cnt saturation: keep in_valid asserted with the FIFO mostly full
      for (int i = 0; i < 75500; i++) step(1'b1, 16'(i));
      chk("drop_saturated", 64'(drop_cnt), 64'hFFFF);
      idle(5);
      chk("drop_held", 64'(drop_cnt), 64'hFFFF);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
